line_buffer_feeder: RTL and testbench
=====================================

Name: line_buffer_feeder

Overview:
- Drives the write side of the per-layer sliding-window line buffer array.
- Accepts Nin-channel input pixels over a valid/ready handshake and scans the padded feature map in raster order.
- Inserts zero-padding beats and generates the line buffer's valid and zero controls.
- Flags each cycle on which the Kh x Kw window (stride 1) is complete, using a valid/ready handshake to the convolution datapath.

Parameters:
Kh, 3, kernel height
Kw, 3, kernel width
h, 5, input feature map height
w, 5, input feature map width
Nin, 3, input channel count
pad_h, 1, zero rows added above and below
pad_w, 1, zero columns added left and right
BIT_WIDTH, 8, data bits per channel

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle frame start pulse, honoured only in IDLE
busy  out  1  high in RUN and WAIT
in_valid  in  1  upstream pixel valid
in_ready  out  1  upstream pixel consumed this cycle
in_data  in  Nin*BIT_WIDTH  upstream pixel, channel i at [i*BIT_WIDTH+:BIT_WIDTH]
line_buffer_valid  out  1  push one beat into the line buffer array
line_buffer_zero  out  1  pushed beat is padding
prev_layer_data  out  Nin*BIT_WIDTH  beat data; in_data on real beats, 0 on pad beats
win_valid  out  1  line buffer output holds a complete window
win_ready  in  1  downstream accepts window
win_row  out  16  output row index of the presented window
win_col  out  16  output column index of the presented window
frame_done  out  1  one-cycle pulse when the last window is accepted

Behaviour:
Definitions:
- Hp = h+2*pad_h; Wp = w+2*pad_w.
- Scan counters r in [0,Hp) and c in [0,Wp), both registered.
- A position is a pad position if r<pad_h, r>=pad_h+h, c<pad_w, or c>=pad_w+w.
- stall = win_valid && !win_ready.

States:
- IDLE: counters held at 0. Moves to RUN on start.
- RUN: scanning.
- WAIT: all Hp*Wp beats pushed; final window pending.

Push rule (RUN only):
- A push occurs when !stall and either:
  - the position is a pad position, or
  - the position is real and in_valid=1.
- line_buffer_valid equals push, combinational.
- line_buffer_zero is 1 on a pad-position push, else 0.
- prev_layer_data equals in_data on a real push, else all zeros.
- in_ready = push && real position. Upstream is never consumed on a pad position or while stalled.

Scan counters:
- On push, c increments.
- When c=Wp-1, c wraps to 0 and r increments.
- The push at (Hp-1,Wp-1) moves the state to WAIT and clears r and c.

Window:
- A push at (r,c) with r>=Kh-1 and c>=Kw-1 sets win_valid on the next cycle.
- On that cycle, win_row is loaded with r-Kh+1 and win_col with c-Kw+1. This matches the one-cycle latency of the line buffer register.
- win_valid clears when win_ready=1 and no new qualifying push occurred in the same cycle.
- A simultaneous accept and new qualifying push keeps win_valid=1 and loads the new indices.
- win_row and win_col hold their values while win_valid=0.

Frame completion:
- WAIT leaves to IDLE when win_valid && win_ready.
- frame_done pulses on that same transition.
- Windows per frame = (Hp-Kh+1)*(Wp-Kw+1). Beats pushed per frame = Hp*Wp. Upstream pixels consumed = h*w.

Boundary conditions:
- start outside IDLE is ignored.
- If Kh>Hp or Kw>Wp, no window is generated. The block still pushes all beats and pulses frame_done one cycle after entering WAIT.
- in_valid while not in RUN is ignored; in_ready=0.

Reset:
- rst low asynchronously forces IDLE.
- Counters, win_valid, win_row, win_col, frame_done and busy go to 0.
- Reset mid-frame abandons the frame; combinational outputs go to 0 with the state.
- The line buffer array contents are not cleared. The next frame overwrites them, because its first window needs Kh full rows.

Optional Feature:
- Macro: LINE_BUFFER_FEEDER_STAT_EN.
- When defined:
  - Adds output stall_cycles (32 bits).
  - It counts cycles in RUN or WAIT with win_valid && !win_ready, plus cycles in RUN at a real position with in_valid=0.
  - Cleared by reset and on start; it saturates at all ones.
- When undefined:
  - The port and its logic are absent.
  - Behaviour is otherwise identical.

Test Plan:
- Defaults, in_valid=1 and win_ready=1 held, start pulsed: 49 pushes in 49 consecutive cycles, 24 pad beats, in_ready high 25 times, 25 windows. The first win_valid appears the cycle after the push at (2,2) with win_row=0, win_col=0. frame_done pulses once after window (4,4).
- Pad check, same setup: the first 8 pushes have line_buffer_zero=1 and prev_layer_data=0. The push at (1,1) carries in_data with zero=0.
- Backpressure: hold win_ready=0 for 5 cycles at window (1,2) -> no push, in_ready=0 and win_row/col held at (1,2). After release, the push resumes and window (1,3) follows with no window lost or duplicated.
- Upstream starvation: drop in_valid for 3 cycles at real position (3,3) -> the scan freezes, and pad positions are not pushed past it. Totals remain 49/25/25.
- Reset at push 30: IDLE, all outputs 0. A new start then yields a complete 25-window frame.
- STAT_EN with the backpressure and starvation stimuli combined: stall_cycles=8.

Source files
------------

// File: rtl/line_buffer_feeder.sv
// Write-side sequencer for the sliding-window line buffer: raster scan with zero padding and window flagging.
// Optional stall statistics output is enabled by defining LINE_BUFFER_FEEDER_STAT_EN.
module line_buffer_feeder #(
    parameter int unsigned Kh        = 3,
    parameter int unsigned Kw        = 3,
    parameter int unsigned h         = 5,
    parameter int unsigned w         = 5,
    parameter int unsigned Nin       = 3,
    parameter int unsigned pad_h     = 1,
    parameter int unsigned pad_w     = 1,
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [Nin*BIT_WIDTH-1:0] in_data,
    output logic                     line_buffer_valid,
    output logic                     line_buffer_zero,
    output logic [Nin*BIT_WIDTH-1:0] prev_layer_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [15:0]              win_row,
    output logic [15:0]              win_col,
    output logic                     frame_done
`ifdef LINE_BUFFER_FEEDER_STAT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int unsigned CW     = 16;
    localparam int unsigned HP     = h + 2 * pad_h;
    localparam int unsigned WP     = w + 2 * pad_w;
    localparam bit          NO_WIN = (Kh > HP) || (Kw > WP);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] r, c, r_nxt, c_nxt;
    logic [CW-1:0] win_row_nxt, win_col_nxt;
    logic          win_valid_nxt, frame_done_nxt;
    logic          is_pad, stall, push, win_qual, last_pos;

    // Next-state, scan counters, window tracking and the combinational push controls
    always_comb begin
        state_nxt      = state;
        r_nxt          = r;
        c_nxt          = c;
        win_valid_nxt  = win_valid;
        win_row_nxt    = win_row;
        win_col_nxt    = win_col;
        frame_done_nxt = 1'b0;

        stall    = win_valid && !win_ready;
        is_pad   = (r < CW'(pad_h)) || (r >= CW'(pad_h + h)) ||
                   (c < CW'(pad_w)) || (c >= CW'(pad_w + w));
        push     = (state == S_RUN) && !stall && (is_pad || in_valid);
        win_qual = push && (r >= CW'(Kh - 1)) && (c >= CW'(Kw - 1));
        last_pos = (r == CW'(HP - 1)) && (c == CW'(WP - 1));

        line_buffer_valid = push;
        line_buffer_zero  = push && is_pad;
        in_ready          = push && !is_pad;
        prev_layer_data   = in_ready ? in_data : '0;

        case (state)
            S_IDLE: begin
                r_nxt = '0;
                c_nxt = '0;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (push) begin
                    if (last_pos) begin
                        state_nxt = S_WAIT;
                        r_nxt     = '0;
                        c_nxt     = '0;
                    end else if (c == CW'(WP - 1)) begin
                        c_nxt = '0;
                        r_nxt = r + CW'(1);
                    end else begin
                        c_nxt = c + CW'(1);
                    end
                end
            end
            S_WAIT: begin
                // With no window possible there is nothing to wait for
                if (NO_WIN || (win_valid && win_ready)) begin
                    state_nxt      = S_IDLE;
                    frame_done_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Window appears one cycle after its bottom-right beat, matching the line buffer register
        if (win_qual) begin
            win_valid_nxt = 1'b1;
            win_row_nxt   = r - CW'(Kh - 1);
            win_col_nxt   = c - CW'(Kw - 1);
        end else if (win_ready) begin
            win_valid_nxt = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            r          <= '0;
            c          <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            r          <= r_nxt;
            c          <= c_nxt;
            win_valid  <= win_valid_nxt;
            win_row    <= win_row_nxt;
            win_col    <= win_col_nxt;
            frame_done <= frame_done_nxt;
            busy       <= (state_nxt != S_IDLE);
        end
    end

`ifdef LINE_BUFFER_FEEDER_STAT_EN
    logic stat_hit;

    // A cycle counts once whether held by the window consumer or starved by upstream
    always_comb begin
        stat_hit = (((state == S_RUN) || (state == S_WAIT)) && stall) ||
                   ((state == S_RUN) && !is_pad && !in_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_cycles <= '0;
        end else if (stat_hit && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Self-checking bench for line_buffer_feeder: scenario table with beat/window scoreboards plus reset and no-window sequences.
module tb_line_buffer_feeder;

    localparam int HP = 7;
    localparam int WP = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, win_ready;
    logic [23:0] in_data;
    logic        busy, in_ready, line_buffer_valid, line_buffer_zero, win_valid, frame_done;
    logic [23:0] prev_layer_data;
    logic [15:0] win_row, win_col;

    logic        nw_start, nw_in_valid, nw_win_ready;
    logic [23:0] nw_in_data;
    logic        nw_busy, nw_in_ready, nw_lbv, nw_lbz, nw_win_valid, nw_frame_done;
    logic [23:0] nw_pld;
    logic [15:0] nw_win_row, nw_win_col;

`ifdef LINE_BUFFER_FEEDER_STAT_EN
    logic [31:0] stall_cycles, nw_stall_cycles;
`endif

    always #5 clk = ~clk;

    line_buffer_feeder u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .line_buffer_valid(line_buffer_valid), .line_buffer_zero(line_buffer_zero),
        .prev_layer_data(prev_layer_data),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
`ifdef LINE_BUFFER_FEEDER_STAT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    // Kernel taller than the padded map: no window can ever form
    line_buffer_feeder #(.Kh(8)) u_nw (
        .clk(clk), .rst(rst), .start(nw_start), .busy(nw_busy),
        .in_valid(nw_in_valid), .in_ready(nw_in_ready), .in_data(nw_in_data),
        .line_buffer_valid(nw_lbv), .line_buffer_zero(nw_lbz),
        .prev_layer_data(nw_pld),
        .win_valid(nw_win_valid), .win_ready(nw_win_ready),
        .win_row(nw_win_row), .win_col(nw_win_col), .frame_done(nw_frame_done)
`ifdef LINE_BUFFER_FEEDER_STAT_EN
        , .stall_cycles(nw_stall_cycles)
`endif
    );

    typedef struct {
        int bp_win;
        int bp_n;
        int starve_beat;
        int starve_n;
        int exp_push;
        int exp_pad;
        int exp_rdy;
        int exp_win;
        int exp_done;
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [24:0] beat_q[$];
    logic [31:0] win_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [23:0] pix(input int k);
        logic [7:0] a, b, d;
        a = 8'(k * 3 + 1);
        b = 8'(k * 7 + 2);
        d = 8'(k + 64);
        return {d, b, a};
    endfunction

    task automatic fill_scoreboard();
        beat_q.delete();
        win_q.delete();
        for (int b = 0; b < HP * WP; b++) begin
            int  br, bc;
            logic pad;
            br  = b / WP;
            bc  = b % WP;
            pad = (br < 1) || (br > 5) || (bc < 1) || (bc > 5);
            beat_q.push_back(pad ? {1'b1, 24'h0} : {1'b0, pix((br - 1) * 5 + bc - 1)});
        end
        for (int wr = 0; wr < 5; wr++)
            for (int wc = 0; wc < 5; wc++)
                win_q.push_back({16'(wr), 16'(wc)});
    endtask

    // One full frame with optional backpressure at window bp_win and starvation at beat starve_beat
    task automatic run_frame(input int bp_win, input int bp_n, input int starve_beat, input int starve_n,
                             output int pushes, output int pads, output int rdys, output int wins,
                             output int dones);
        int   beat, pix_idx, bp_left, st_left;
        logic exp_wv, exp_done, finished, qual, starving, stalling;
        logic [24:0] eb;
        logic [31:0] ew;
        pushes = 0; pads = 0; rdys = 0; wins = 0; dones = 0;
        beat = 0; pix_idx = 0; bp_left = bp_n; st_left = starve_n;
        exp_wv = 1'b0; exp_done = 1'b0; finished = 1'b0;
        fill_scoreboard();

        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; win_ready = 1'b1; in_data = pix(0);
        #1;
        check("idle_lbv", 32'(line_buffer_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            starving  = (beat == starve_beat) && (st_left > 0);
            stalling  = (wins == bp_win) && (bp_left > 0) && exp_wv;
            start     = (cyc == 5);
            in_valid  = !starving;
            in_data   = pix(pix_idx);
            win_ready = !stalling;
            #1;
            check("win_valid", 32'(win_valid), 32'(exp_wv));
            if (exp_wv && win_q.size() > 0) begin
                check("win_row_shown", 32'(win_row), 32'(win_q[0][31:16]));
                check("win_col_shown", 32'(win_col), 32'(win_q[0][15:0]));
            end
            if (starving || stalling) begin
                check(starving ? "starve_no_push" : "stall_no_push", 32'(line_buffer_valid), 32'd0);
                check(starving ? "starve_in_ready" : "stall_in_ready", 32'(in_ready), 32'd0);
                if (starving) st_left--;
                if (stalling) bp_left--;
            end
            qual = 1'b0;
            if (line_buffer_valid) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_beat: push seen after %0d beats, expected none", beat);
                end else begin
                    eb = beat_q.pop_front();
                    check("beat_zero", 32'(line_buffer_zero), 32'(eb[24]));
                    check("beat_data", 32'(prev_layer_data), 32'(eb[23:0]));
                    check("beat_in_ready", 32'(in_ready), 32'(!eb[24]));
                end
                qual = ((beat / WP) >= 2) && ((beat % WP) >= 2);
                pushes++;
                if (line_buffer_zero) pads++;
                beat++;
            end
            if (in_ready) begin
                rdys++;
                pix_idx++;
            end
            check("frame_done", 32'(frame_done), 32'(exp_done));
            if (frame_done) begin
                dones++;
                finished = 1'b1;
                check("busy_after_done", 32'(busy), 32'd0);
            end
            exp_done = 1'b0;
            if (win_valid && win_ready) begin
                if (win_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_window: accept at (%0d,%0d), expected none", win_row, win_col);
                end else begin
                    ew = win_q.pop_front();
                    check("win_row", 32'(win_row), 32'(ew[31:16]));
                    check("win_col", 32'(win_col), 32'(ew[15:0]));
                    if (win_q.size() == 0) exp_done = 1'b1;
                end
                wins++;
            end
            exp_wv = qual ? 1'b1 : (win_ready ? 1'b0 : exp_wv);
        end
        start = 1'b0;
        if (!finished) begin
            n_checks++;
            $display("FAIL frame_timeout: pushes %0d windows %0d, expected frame_done", pushes, wins);
        end
        check("beats_left", 32'(beat_q.size()), 32'd0);
        check("windows_left", 32'(win_q.size()), 32'd0);
    endtask

    initial begin
        int pushes, pads, rdys, wins, dones, last, donecyc, wvs;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0; in_data = '0;
        nw_start = 1'b0; nw_in_valid = 1'b0; nw_win_ready = 1'b1; nw_in_data = 24'h123456;

        vecs[0] = '{-1, 0, -1, 0, 49, 24, 25, 25, 1};
        vecs[1] = '{ 7, 5, -1, 0, 49, 24, 25, 25, 1};
        vecs[2] = '{-1, 0, 24, 3, 49, 24, 25, 25, 1};
        vecs[3] = '{ 7, 5, 24, 3, 49, 24, 25, 25, 1};

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_win_valid", 32'(win_valid), 32'd0);
        check("rst_win_row", 32'(win_row), 32'd0);
        check("rst_win_col", 32'(win_col), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].bp_win, vecs[i].bp_n, vecs[i].starve_beat, vecs[i].starve_n,
                      pushes, pads, rdys, wins, dones);
            check("tot_push", 32'(pushes), 32'(vecs[i].exp_push));
            check("tot_pad", 32'(pads), 32'(vecs[i].exp_pad));
            check("tot_in_ready", 32'(rdys), 32'(vecs[i].exp_rdy));
            check("tot_windows", 32'(wins), 32'(vecs[i].exp_win));
            check("tot_done", 32'(dones), 32'(vecs[i].exp_done));
`ifdef LINE_BUFFER_FEEDER_STAT_EN
            if (i == 3) check("stall_cycles", stall_cycles, 32'd8);
`endif
        end

        // Reset part-way through a frame, then a clean frame must follow
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
        pushes = 0; rdys = 0;
        for (int cyc = 0; cyc < 100 && pushes < 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            in_data = pix(rdys);
            #1;
            if (line_buffer_valid) pushes++;
            if (in_ready) rdys++;
        end
        check("pre_reset_pushes", 32'(pushes), 32'd30);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_lbv", 32'(line_buffer_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_win_valid", 32'(win_valid), 32'd0);
        check("mid_rst_win_row", 32'(win_row), 32'd0);
        check("mid_rst_win_col", 32'(win_col), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(-1, 0, -1, 0, pushes, pads, rdys, wins, dones);
        check("post_rst_push", 32'(pushes), 32'd49);
        check("post_rst_windows", 32'(wins), 32'd25);
        check("post_rst_done", 32'(dones), 32'd1);

        // No-window configuration: all beats pushed, frame_done one cycle after entering WAIT
        @(negedge clk);
        nw_start = 1'b1; nw_in_valid = 1'b1;
        pushes = 0; last = -1; donecyc = -1; wvs = 0;
        for (int cyc = 0; cyc < 200 && donecyc < 0; cyc++) begin
            @(negedge clk);
            nw_start = 1'b0;
            #1;
            if (nw_lbv) begin
                pushes++;
                last = cyc;
            end
            if (nw_win_valid) wvs++;
            if (nw_frame_done) donecyc = cyc;
        end
        if (donecyc < 0) begin
            n_checks++;
            $display("FAIL nw_timeout: pushes %0d, expected frame_done", pushes);
        end else begin
            check("nw_done_delay", 32'(donecyc - last), 32'd2);
        end
        check("nw_pushes", 32'(pushes), 32'd49);
        check("nw_no_window", 32'(wvs), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
